// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch sequencer. Walks a PC over an INST_CAP-word instruction
// memory with synchronous reads. Returned instructions go to decode through a
// valid/ready handshake, with a one-entry skid buffer so that one instruction
// per cycle is sustained under backpressure. Handles start, redirect (flush)
// and end-of-program completion.
//
// Ports:
//   clk          clock, rising edge
//   rstn         synchronous active-low reset
//   start        begin fetching at PC 0 (IDLE/DONE only)
//   redirect     flush and reload PC from redirect_pc (RUN only)
//   redirect_pc  new PC
//   mem_rd       memory read strobe (combinational)
//   mem_addr     memory read address, equals pc (combinational)
//   mem_rdata    read data, valid the cycle after mem_rd
//   inst         instruction to decode (registered)
//   inst_pc      PC of inst (registered)
//   inst_valid   inst/inst_pc valid
//   inst_ready   decode accepts
//   done         program exhausted (registered)
module fetch_ctrl #(
   parameter int INST_CAP = 5,
   parameter int INST_LEN = 17,
   parameter int PC_W     = $clog2(INST_CAP) + 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                redirect,
   input  logic [PC_W-1:0]     redirect_pc,
   output logic                mem_rd,
   output logic [PC_W-1:0]     mem_addr,
   input  logic [INST_LEN-1:0] mem_rdata,
   output logic [INST_LEN-1:0] inst,
   output logic [PC_W-1:0]     inst_pc,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [PC_W-1:0] CAP = PC_W'(INST_CAP);

   state_t              state;
   logic [PC_W-1:0]     pc;
   logic [INST_LEN-1:0] skid;
   logic [PC_W-1:0]     skid_pc;
   logic                skid_valid;
   logic                inflight;
   logic [PC_W-1:0]     inflight_pc;

   logic                pop;
   logic                out_free;
   logic [1:0]          occ;
   logic [1:0]          occ_after;

   // Issue decision. Occupancy counts every instruction already owned by this
   // block (output register, skid, read in flight); a new read is only issued
   // when, after this cycle's pop, at most one slot is taken, so the returning
   // word always has somewhere to land.
   always_comb begin
      pop       = inst_valid & inst_ready;
      out_free  = ~inst_valid | pop;
      occ       = {1'b0, inst_valid} + {1'b0, skid_valid} + {1'b0, inflight};
      occ_after = occ - {1'b0, pop};
      mem_addr  = pc;
      mem_rd    = rstn && (state == RUN) && (pc < CAP) && !redirect
                  && (occ_after < 2'd2);
   end

   // Single sequential block: FSM, PC, return path and skid buffer.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         pc          <= '0;
         inst        <= '0;
         inst_pc     <= '0;
         inst_valid  <= 1'b0;
         skid        <= '0;
         skid_pc     <= '0;
         skid_valid  <= 1'b0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               inflight <= 1'b0;
               if (start) begin
                  pc    <= '0;
                  state <= RUN;
               end
            end

            DONE: begin
               inflight   <= 1'b0;
               inst_valid <= 1'b0;
               if (start) begin
                  pc    <= '0;
                  done  <= 1'b0;
                  state <= RUN;
               end
            end

            RUN: begin
               if (redirect) begin
                  // Any handshake this cycle has already completed; everything
                  // younger is dropped. An out-of-range target leaves pc past
                  // the end so the completion check retires to DONE next edge.
                  inst_valid <= 1'b0;
                  skid_valid <= 1'b0;
                  inflight   <= 1'b0;
                  pc         <= redirect_pc;
               end else begin
                  inflight <= mem_rd;
                  if (mem_rd) begin
                     inflight_pc <= pc;
                     pc          <= pc + PC_W'(1);
                  end

                  // Return path: the skid is always older than the word in
                  // flight, so it refills the output first.
                  if (out_free) begin
                     if (skid_valid) begin
                        inst       <= skid;
                        inst_pc    <= skid_pc;
                        inst_valid <= 1'b1;
                        skid_valid <= inflight;
                        if (inflight) begin
                           skid    <= mem_rdata;
                           skid_pc <= inflight_pc;
                        end
                     end else if (inflight) begin
                        inst       <= mem_rdata;
                        inst_pc    <= inflight_pc;
                        inst_valid <= 1'b1;
                     end else begin
                        inst_valid <= 1'b0;
                     end
                  end else if (inflight) begin
                     skid       <= mem_rdata;
                     skid_pc    <= inflight_pc;
                     skid_valid <= 1'b1;
                  end

                  if ((pc >= CAP) && !inflight && !skid_valid && out_free) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
